// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package loader_pkg;
  typedef enum logic [1:0] {HEADER, PAYLOAD, DONE, ERROR} loader_state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned HEADER_BYTES   = 4;
endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface instruction_loader_if;
  logic [7:0]  iByte;
  logic        iByteValid;
  logic        oByteReady;
  logic        oWrEn;
  logic [31:0] oWrAddr;
  logic [31:0] oWrData;

  modport slave  (input iByte, iByteValid, output oByteReady, oWrEn, oWrAddr, oWrData);
  modport master (output iByte, iByteValid, input oByteReady, oWrEn, oWrAddr, oWrData);
endinterface

// File: rtl/instruction_loader_byte_packer.sv
// Little-endian byte-to-word packer; the completing byte is merged combinationally
// so the full word is available on the same edge that accepts it.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        acc,
  input  logic        clr,
  input  logic [7:0]  din,
  output logic [8*BYTES_PER_WORD-1:0] word,
  output logic        word_done
);
  localparam int unsigned IW = $clog2(BYTES_PER_WORD);

  logic [IW-1:0]                     idx_q;
  logic [8*(BYTES_PER_WORD-1)-1:0]   sr_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx_q <= '0;
      sr_q  <= '0;
    end else if (acc) begin
      idx_q <= idx_q + 1'b1;
      sr_q  <= {din, sr_q[8*(BYTES_PER_WORD-1)-1:8]};
    end
  end

  assign word      = {din, sr_q};
  assign word_done = acc && (idx_q == IW'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/instruction_loader.sv
// Boot loader: header word count, then payload words written to instruction memory
// at consecutive addresses; CPU held in reset until the last write has committed.
module instruction_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iStart,
  output logic oCpuHold,
  output logic oDone,
  output logic oError,
  instruction_loader_if.slave bus
);
  localparam logic [32:0] CAP = 33'd1 << ADDR_WIDTH;

  loader_state_t         state_q, state_d;
  logic [ADDR_WIDTH:0]   widx_q;
  logic [31:0]           count_q;
  logic                  wr_en_q;
  logic [31:0]           wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  hold_q, done_q, err_q;

  logic        ready, acc, start_ok, last_word;
  logic [31:0] pk_word;
  logic        pk_done;

  assign ready     = !iRst && (state_q == HEADER || state_q == PAYLOAD);
  assign acc       = bus.iByteValid && ready;
  assign start_ok  = iStart && (state_q == DONE || state_q == ERROR);
  assign last_word = (32'(widx_q) + 32'd1) == count_q;

  byte_packer u_pack (
    .clk       (iClk),
    .rst       (iRst),
    .acc       (acc),
    .clr       (start_ok),
    .din       (bus.iByte),
    .word      (pk_word),
    .word_done (pk_done)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HEADER: if (pk_done) begin
        if (pk_word == 32'd0)             state_d = DONE;
        else if ({1'b0, pk_word} > CAP)   state_d = ERROR;
        else                              state_d = PAYLOAD;
      end
      PAYLOAD: if (pk_done && last_word)  state_d = DONE;
      DONE, ERROR: if (iStart)            state_d = HEADER;
      default:                            state_d = HEADER;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= HEADER;
      widx_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= BASE_ADDR;
      wr_data_q <= '0;
      hold_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_en_q <= 1'b0;
      // Status lags the state by one edge so the CPU is released only after
      // the final write pulse; a restart takes effect on its own edge.
      if (start_ok) begin
        widx_q  <= '0;
        count_q <= '0;
        hold_q  <= 1'b1;
        done_q  <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        hold_q  <= state_q != DONE;
        done_q  <= state_q == DONE;
        err_q   <= state_q == ERROR;
      end
      if (state_q == HEADER && pk_done)
        count_q <= pk_word;
      if (state_q == PAYLOAD && pk_done) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= BASE_ADDR + (32'(widx_q) << 2);
        wr_data_q <= pk_word;
        widx_q    <= widx_q + 1'b1;
      end
    end
  end

  assign bus.oByteReady = ready;
  assign bus.oWrEn      = wr_en_q;
  assign bus.oWrAddr    = wr_addr_q;
  assign bus.oWrData    = wr_data_q;
  assign oCpuHold       = hold_q;
  assign oDone          = done_q;
  assign oError         = err_q;
endmodule

// File: tb/tb_instruction_loader.sv
// Randomized bench for instruction_loader; expected writes derived from the image itself.
module tb_instruction_loader;
  localparam int unsigned AW   = 2;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam logic [31:0] CAP  = 32'd1 << AW;

  logic iClk, iRst, start, hold, done, err;
  instruction_loader_if bus();

  instruction_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .BASE_ADDR(BASE)) dut (
    .iClk     (iClk),
    .iRst     (iRst),
    .iStart   (start),
    .oCpuHold (hold),
    .oDone    (done),
    .oError   (err),
    .bus      (bus)
  );

  int checks = 0, failures = 0;
  int seen_wr = 0, exp_wr = 0;
  logic [31:0] words [8];

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  always @(negedge iClk) if (bus.oWrEn === 1'b1) seen_wr++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int stall);
    int n = 0;
    repeat (stall) begin
      bus.iByteValid = 1'b0;
      @(posedge iClk); @(negedge iClk);
    end
    bus.iByte      = b;
    bus.iByteValid = 1'b1;
    start          = ($urandom_range(3, 0) == 0);
    while (bus.oByteReady !== 1'b1 && n < 50) begin
      @(posedge iClk); @(negedge iClk); n++;
    end
    if (n == 50) chk("ready_tmo", bus.oByteReady, 1);
    @(posedge iClk); @(negedge iClk);
    bus.iByteValid = 1'b0;
    start          = 1'b0;
  endtask

  // Sends a complete image (header + payload if legal) and checks every write
  // and the completion / error timing against the image's own contents.
  task automatic load(input logic [31:0] cnt, input int stall, input bit rnd);
    int nw;
    bit bad;
    logic [31:0] w;
    bad = (cnt > CAP);
    nw  = (bad || cnt == 0) ? 0 : int'(cnt);
    for (int k = 0; k < 4; k++) begin
      send_byte(cnt[8*k +: 8], rnd ? int'($urandom_range(stall, 0)) : stall);
      chk("hdr_wren", bus.oWrEn, 0);
    end
    for (int i = 0; i < nw; i++) begin
      w = words[i];
      for (int j = 0; j < 4; j++) begin
        send_byte(w[8*j +: 8], rnd ? int'($urandom_range(stall, 0)) : stall);
        if (j == 3) begin
          chk("wr_en", bus.oWrEn, 1);
          chk("wr_addr", bus.oWrAddr, BASE + 32'(4 * i));
          chk("wr_data", bus.oWrData, w);
        end else begin
          chk("mid_wren", bus.oWrEn, 0);
        end
      end
    end
    exp_wr += nw;
    chk("pre_done", done, 0);
    chk("pre_hold", hold, 1);
    chk("pre_err", err, 0);
    @(posedge iClk); @(negedge iClk);
    chk("done", done, bad ? 0 : 1);
    chk("hold", hold, bad ? 1 : 0);
    chk("error", err, bad ? 1 : 0);
    chk("end_ready", bus.oByteReady, 0);
    chk("end_wren", bus.oWrEn, 0);
  endtask

  task automatic restart();
    start = 1'b1;
    @(posedge iClk); @(negedge iClk);
    start = 1'b0;
    chk("st_done", done, 0);
    chk("st_err", err, 0);
    chk("st_hold", hold, 1);
    chk("st_ready", bus.oByteReady, 1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_wren", bus.oWrEn, 0);
    chk("rst_addr", bus.oWrAddr, BASE);
    chk("rst_data", bus.oWrData, 0);
    chk("rst_hold", hold, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", bus.oByteReady, 0);
  endtask

  initial begin
    logic [31:0] c;
    iRst = 1'b1; start = 1'b0;
    bus.iByte = 8'h00; bus.iByteValid = 1'b0;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    chk_reset_vals();
    iRst = 1'b0;
    @(posedge iClk); @(negedge iClk);
    chk("post_rst_ready", bus.oByteReady, 1);

    // basic back-to-back load, then the same image with fixed 3-cycle stalls
    words[0] = 32'h0050_0013; words[1] = 32'h00A0_05B3;
    load(32'd2, 0, 1'b0);
    restart();
    load(32'd2, 3, 1'b0);
    restart();

    // zero length and overflow, then a full-capacity image
    load(32'd0, 0, 1'b0);
    restart();
    load(32'd5, 0, 1'b0);
    restart();
    for (int i = 0; i < 4; i++) words[i] = $urandom();
    load(CAP, 1, 1'b1);
    restart();

    // reset after two payload bytes; stale bytes must not leak into the next word
    c = 32'd2;
    for (int k = 0; k < 4; k++) send_byte(c[8*k +: 8], 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    iRst = 1'b1;
    @(posedge iClk); @(negedge iClk);
    chk_reset_vals();
    iRst = 1'b0;
    @(posedge iClk); @(negedge iClk);
    chk("rst2_ready", bus.oByteReady, 1);
    words[0] = 32'h1234_5678;
    load(32'd1, 0, 1'b0);
    restart();

    // random images including zero, full and oversize counts
    for (int t = 0; t < 12; t++) begin
      c = $urandom_range(6, 0);
      if ($urandom_range(5, 0) == 0) c = $urandom() | 32'h0000_0100;
      for (int i = 0; i < 4; i++) words[i] = $urandom();
      load(c, 2, 1'b1);
      restart();
    end

    chk("wr_total", seen_wr, exp_wr);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instruction_loader.md
# instruction_loader

Boot-time writer for instruction memory. It accepts a byte stream over a valid/ready handshake: a 4-byte little-endian word count, followed by that many 32-bit words, each sent least-significant byte first. It packs the bytes into words and drives the instruction memory write port at consecutive word addresses from `BASE_ADDR`. It holds the CPU in reset until the image is fully written.

## Interface
Parameters:
- `ADDR_WIDTH`, 12: word-address bits of instruction memory; capacity is 2**ADDR_WIDTH words.
- `DATA_WIDTH`, 32: instruction width; fixed at 32 (4 bytes per word).
- `BASE_ADDR`, 32'h0000_0000: byte address of the first word written.

Ports:
- `iClk` in 1: the single clock; all state changes on its rising edge.
- `iRst` in 1: synchronous, active-high reset.
- `iByte` in 8: stream data byte.
- `iByteValid` in 1: `iByte` is valid.
- `oByteReady` out 1: loader accepts a byte this cycle.
- `iStart` in 1: restarts a load from DONE or ERROR.
- `oWrEn` out 1: one-cycle write strobe to instruction memory.
- `oWrAddr` out 32: byte address of the write, word-aligned.
- `oWrData` out 32: instruction word.
- `oCpuHold` out 1: keeps the CPU in reset / PC frozen.
- `oDone` out 1: image fully written.
- `oError` out 1: header word count exceeds capacity.

## Operation
- A byte is accepted on a rising edge where `iByteValid && oByteReady`. `oByteReady` is 1 in HEADER and PAYLOAD, and 0 in every other state and while `iRst` is high.
- States:
  - **HEADER**: collects 4 bytes into `count[31:0]`, little-endian.
    - On the 4th byte: if `count == 0`, go to DONE.
    - Else if `count > 2**ADDR_WIDTH`, go to ERROR.
    - Else go to PAYLOAD.
  - **PAYLOAD**: a 2-bit byte index packs bytes into `word[8*i +: 8]`.
    - On the 4th byte, register the write: `oWrData` = assembled word, `oWrAddr` = `BASE_ADDR + 4*widx`; then increment `widx`.
    - After the word where `widx+1 == count`, go to DONE.
  - **DONE**: ignores the stream. `iStart` moves to HEADER and clears the byte index, `widx` and `count`.
  - **ERROR**: `oError` is 1 and `oCpuHold` stays 1. `iStart` moves to HEADER.
- `iStart` is ignored in HEADER and PAYLOAD.
- Address arithmetic is 32-bit and wraps modulo 2**32. `widx` is ADDR_WIDTH+1 bits wide.
- A `count` of exactly 2**ADDR_WIDTH is legal and fills memory completely.
- `iByteValid` with `oByteReady` low is not a transfer and is not counted.
- A stall (`iByteValid` low) inside a word or inside the header holds all state.

## Timing
- Reset values:
  - state HEADER, byte index 0, `widx` 0, `count` 0.
  - `oWrEn` 0, `oWrAddr` `BASE_ADDR`, `oWrData` 0.
  - `oCpuHold` 1, `oDone` 0, `oError` 0.
- `oByteReady` is 1 from the first cycle after `iRst` falls.
- Let edge E be the edge that accepts the 4th byte of a payload word. `oWrEn` is high for exactly the cycle after E; `oWrAddr` and `oWrData` are valid in that cycle and hold afterwards.
- Throughput is one byte per cycle, giving back-to-back words with `oWrEn` high every 4th cycle.
- Let edge E be the edge accepting the final payload byte. The state is DONE from E; `oDone` rises and `oCpuHold` falls at edge E+1, coinciding with the end of the last `oWrEn` pulse.
  - The CPU therefore never runs before the final write commits.
- For `count == 0`, `oDone` rises and `oCpuHold` falls one edge after the 4th header byte. No `oWrEn` is produced.
- `oError` rises one edge after the 4th header byte, and no write is ever issued for that image.
- `iStart` accepted at edge S:
  - `oDone` and `oError` drop, and `oCpuHold` rises, at edge S.
  - `oByteReady` is 1 in the cycle after S.
- `iRst` mid-load aborts immediately: all values return to reset on the same edge. A partial word is discarded, and memory already written is left as-is.

## Structure
- Shared package `loader_pkg` holds:
  - the state enum `loader_state_t` {HEADER, PAYLOAD, DONE, ERROR};
  - `BYTES_PER_WORD = 4`;
  - `HEADER_BYTES = 4`.
- One sub-module, `byte_packer`: a 4-byte little-endian shift/pack register.
  - Inputs: accept strobe, byte, clear.
  - Outputs: packed word and a "word complete" pulse.
  - It is reused for both the header count and payload words.
- The top level owns the FSM, `widx`, capacity check, address generation and output registers.

## Test plan
- **Basic load.** Bytes 02 00 00 00, 13 00 50 00, B3 05 A0 00 sent back-to-back with `BASE_ADDR` 0 -> `oWrEn` pulses with (0x0, 0x00500013) then (0x4, 0x00A005B3). `oDone` rises, and `oCpuHold` falls, one cycle after the last pulse.
- **Stalls.** Same image with `iByteValid` deasserted for 3 cycles between every byte -> identical writes and values, with no extra or missing `oWrEn`.
- **Zero length.** Header 00 00 00 00 -> no `oWrEn`; `oDone`=1 and `oCpuHold`=0 one edge after the 4th byte; `oByteReady`=0 afterwards.
- **Overflow.** With `ADDR_WIDTH`=2, header 05 00 00 00 -> `oError`=1, `oCpuHold`=1 and no writes. Then `iStart` followed by header 04 00 00 00 and 16 bytes -> 4 writes at 0x0, 0x4, 0x8, 0xC and `oDone`=1.
- **Reset mid-word.** Assert `iRst` after 2 payload bytes -> all outputs at reset values. A fresh 1-word image then writes to `BASE_ADDR`, and the stale bytes are not merged into it.
- **Reload.** Assert `iStart` in DONE -> `oCpuHold`=1 and `oDone`=0 at that edge; the second image overwrites from `BASE_ADDR` (here 32'h100) upward.
